// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-side arbiter and, later, the
//   read-side scheduler: FSM state encoding, a constant-evaluable clog2,
//   and the default sizing constants.
package fifo_arb_pkg;

  // Arbiter FSM states: IDLE is the arbitration cycle, GRANT owns the port.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_BURST_LEN  = 4;

  // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational rotating priority encoder. Searches req upward starting
//   at index ptr, wrapping from N-1 back to 0, and returns the first set bit.
// Ports
//   req  in  N  request vector
//   ptr  in  W  index with highest priority this cycle
//   any  out 1  at least one request bit set
//   idx  out W  index of the winning request (0 when any=0)
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  int k;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[W'(k)]) begin
        any = 1'b1;
        idx = W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, burst-locking arbiter sharing one FIFO write port among
//   N_REQ requesters. IDLE spends one cycle picking the next owner; GRANT
//   forwards that owner's beats to the FIFO until its burst ends, it reaches
//   BURST_LEN beats, or it drops valid.
//
// Handshake: a beat from requester i transfers in the cycle where
//   req_valid[i] && req_ready[i] are both high. req_ready only depends on the
//   grant and fifo_full, never on req_valid, so requesters may raise valid
//   whenever they like; once raised they hold data/last stable until ready.
//   fifo_wr_en is exactly that transfer condition for the owner.
//
// Ports
//   clk           in   1                 rising-edge clock
//   rst           in   1                 synchronous active-high reset
//   req_valid     in   N_REQ             per-requester beat valid
//   req_data      in   N_REQ*DATA_WIDTH  packed beats, requester i at [i*DW +: DW]
//   req_last      in   N_REQ             final beat of a requester's burst
//   req_ready     out  N_REQ             beat accepted when valid & ready
//   fifo_full     in   1                 FIFO full flag
//   fifo_wr_en    out  1                 FIFO write strobe
//   fifo_wr_data  out  DATA_WIDTH        FIFO write data (0 when not writing)
//   grant_vld     out  1                 a requester owns the port
//   grant_id      out  ID_WIDTH          index of the owner
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int ID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic                        grant_vld,
  output logic [ID_WIDTH-1:0]         grant_id
);

  localparam int CNT_W = clog2(BURST_LEN) + 1;

  // All architectural state lives in one struct so it can be probed as a unit.
  typedef struct packed {
    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] grant_id;
    logic [CNT_W-1:0]    beat_cnt;
  } arb_regs_t;

  arb_regs_t cur;
  arb_regs_t nxt;

  logic [DATA_WIDTH-1:0] req_data_arr [N_REQ];
  logic                  pick_any;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  accept;
  logic                  release_now;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N (N_REQ),
    .W (ID_WIDTH)
  ) u_pick (
    .req (req_valid),
    .ptr (cur.rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign sel_valid = req_valid[cur.grant_id];
  assign sel_last  = req_last[cur.grant_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      cur.state    <= ST_IDLE;
      cur.rr_ptr   <= '0;
      cur.grant_id <= '0;
      cur.beat_cnt <= '0;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt          = cur;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_vld    = 1'b0;
    grant_id     = cur.grant_id;
    accept       = 1'b0;
    release_now  = 1'b0;

    case (cur.state)
      ST_IDLE: begin
        if (pick_any) begin
          nxt.state    = ST_GRANT;
          nxt.grant_id = pick_idx;
          nxt.beat_cnt = '0;
        end
      end

      ST_GRANT: begin
        grant_vld                = 1'b1;
        req_ready[cur.grant_id]  = !fifo_full;
        accept                   = sel_valid && !fifo_full;
        fifo_wr_en               = accept;
        if (accept) begin
          fifo_wr_data = req_data_arr[cur.grant_id];
        end

        // A dropped valid releases even while the FIFO is full, so an idle
        // owner cannot hold the port through a stall.
        if (!sel_valid) begin
          release_now = 1'b1;
        end else if (accept) begin
          if (sel_last || (cur.beat_cnt == CNT_W'(BURST_LEN - 1))) begin
            release_now = 1'b1;
          end else begin
            nxt.beat_cnt = cur.beat_cnt + 1'b1;
          end
        end

        if (release_now) begin
          nxt.state    = ST_IDLE;
          nxt.beat_cnt = '0;
          if (cur.grant_id == ID_WIDTH'(N_REQ - 1)) begin
            nxt.rr_ptr = '0;
          end else begin
            nxt.rr_ptr = cur.grant_id + 1'b1;
          end
        end
      end

      default: begin
        nxt.state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=10, BURST_LEN=4).
//   Each requester is a simple source streaming base+n; expected FIFO writes
//   ({grant_id, data}) and per-cycle wr_en/grant_vld patterns are hand-written.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 10;
  localparam int IW = 2;
  localparam int EW = IW + DW;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            grant_vld;
  logic [IW-1:0]   grant_id;

  int n_vec;
  int n_miscmp;

  logic [EW-1:0] exp_q[$];

  int src_start [N];
  int src_len   [N];
  int src_base  [N];
  int src_last  [N];
  int src_cnt   [N];

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (4),
    .ID_WIDTH   (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_vld    (grant_vld),
    .grant_id     (grant_id)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_start[i] = 0;
      src_len[i]   = 0;
      src_base[i]  = 0;
      src_last[i]  = -1;
      src_cnt[i]   = 0;
    end
  endtask

  task automatic set_source(input int i, input int start, input int len, input int base,
                            input int last_at);
    src_start[i] = start;
    src_len[i]   = len;
    src_base[i]  = base;
    src_last[i]  = last_at;
    src_cnt[i]   = 0;
  endtask

  task automatic drive_sources(input int c);
    logic v;
    for (int i = 0; i < N; i++) begin
      v = (c >= src_start[i]) && (src_cnt[i] < src_len[i]);
      req_valid[i]          = v;
      req_data[i*DW +: DW]  = DW'(src_base[i] + src_cnt[i]);
      req_last[i]           = v && (src_cnt[i] == src_last[i]);
    end
  endtask

  task automatic push_exp(input int g, input int d);
    exp_q.push_back({IW'(g), DW'(d)});
  endtask

  // Leaves the bench at posedge+1 with rst low, sources idle, pointer at 0.
  task automatic clean();
    clear_sources();
    drive_sources(0);
    fifo_full = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs ncyc cycles. Bit c of each pattern applies to cycle c (cycle 0 is
  // the one right after entry). Outputs are sampled on the falling edge.
  task automatic run(input string tag, input int ncyc, input logic [31:0] wr_pat,
                     input logic [31:0] gv_pat, input logic [31:0] full_pat,
                     input logic [31:0] rst_pat);
    logic [N-1:0]  acc;
    logic          prev_rst;
    logic [EW-1:0] e;
    prev_rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      fifo_full = full_pat[c];
      rst       = rst_pat[c];
      drive_sources(c);
      @(negedge clk);
      check({tag, " wr_en"}, 32'(fifo_wr_en), 32'(wr_pat[c]));
      check({tag, " grant_vld"}, 32'(grant_vld), 32'(gv_pat[c]));
      check({tag, " ready_onehot"}, 32'($countones(req_ready) <= 1), 32'd1);
      if (full_pat[c]) check({tag, " ready_when_full"}, 32'(req_ready), 32'd0);
      if (prev_rst) begin
        check({tag, " grant_id_after_rst"}, 32'(grant_id), 32'd0);
        check({tag, " ready_after_rst"}, 32'(req_ready), 32'd0);
        check({tag, " wr_data_after_rst"}, 32'(fifo_wr_data), 32'd0);
      end
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          check({tag, " unexpected_write"}, 32'({grant_id, fifo_wr_data}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check({tag, " write"}, 32'({grant_id, fifo_wr_data}), 32'(e));
        end
      end
      acc = req_valid & req_ready;
      prev_rst = rst_pat[c];
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) src_cnt[i]++;
      end
    end
    check({tag, " writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pat;
    n_vec     = 0;
    n_miscmp  = 0;
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset held two cycles with every requester valid.
    clear_sources();
    for (int i = 0; i < N; i++) set_source(i, 0, 100, i * 100, -1);
    drive_sources(0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("rst wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst grant_vld", 32'(grant_vld), 32'd0);
      check("rst grant_id", 32'(grant_id), 32'd0);
      check("rst wr_data", 32'(fifo_wr_data), 32'd0);
    end
    clean();

    // Single requester 1 streams 0..5: four writes, one bubble, two writes,
    // then a GRANT cycle that releases on dropped valid.
    set_source(1, 0, 6, 0, -1);
    for (int d = 0; d < 6; d++) push_exp(1, d);
    run("single", 9, 32'h0DE, 32'h1DE, 32'h0, 32'h0);
    clean();

    // Four-way contention: grants 0,1,2,3,0 with 4 writes each and a gap.
    for (int i = 0; i < N; i++) set_source(i, 0, (i == 0) ? 8 : 4, i * 100, -1);
    pat = '0;
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        pat[1 + 5*g + b] = 1'b1;
        push_exp(g % 4, (g % 4) * 100 + ((g == 4) ? 4 + b : b));
      end
    end
    run("contend", 26, pat, pat, 32'h0, 32'h0);
    clean();

    // Backpressure: full for three cycles after beat 1 of requester 0.
    set_source(0, 0, 4, 0, -1);
    for (int d = 0; d < 4; d++) push_exp(0, d);
    run("backpressure", 9, 32'h0C6, 32'h0FE, 32'h038, 32'h0);
    clean();

    // Early last: requester 2 ends after two beats, requester 3 then owns.
    set_source(2, 0, 2, 200, 1);
    set_source(3, 0, 4, 300, -1);
    push_exp(2, 200);
    push_exp(2, 201);
    for (int d = 0; d < 4; d++) push_exp(3, 300 + d);
    run("early_last", 9, 32'h0F6, 32'h0F6, 32'h0, 32'h0);
    clean();

    // Reset mid-burst: rst in cycle 3 (beat 202 still lands that cycle),
    // then requester 0 wins from the reset pointer.
    set_source(2, 0, 8, 200, -1);
    set_source(0, 4, 2, 0, -1);
    push_exp(2, 200);
    push_exp(2, 201);
    push_exp(2, 202);
    push_exp(0, 0);
    push_exp(0, 1);
    run("rst_mid", 9, 32'h06E, 32'h0EE, 32'h0, 32'h008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
